// File: rtl/spart_pkg.sv
// Shared constants and state types for the SPART bus UART.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int OVS = 16;
    localparam logic [15:0] DEFAULT_DIV = 16'd1302;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud divisor and down-counter producing the x16 oversample enable.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] RESET_DIV = spart_pkg::DEFAULT_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [7:0]  wdata,
    output logic [15:0] div,
    output logic        en
);

    logic [15:0] cnt;
    logic        reload;

    assign en = (cnt == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div    <= RESET_DIV;
            cnt    <= RESET_DIV;
            reload <= 1'b0;
        end else begin
            reload <= 1'b0;
            if (we && addr == ADDR_DBL) begin
                div[7:0] <= wdata;
                reload   <= 1'b1;
            end
            if (we && addr == ADDR_DBH) begin
                div[15:8] <= wdata;
                reload    <= 1'b1;
            end
            // Reload one cycle after a divisor write so the new value is used.
            if (reload || en)
                cnt <= div;
            else
                cnt <= cnt - 16'd1;
        end
    end

endmodule

// File: rtl/spart_core.sv
// SPART top: bus register decode, 8N1 transmitter and oversampling receiver.
module spart_core #(
    parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    import spart_pkg::*;

    localparam logic [3:0] LAST_TICK = 4'(OVS - 1);
    localparam logic [3:0] MID_TICK  = 4'(OVS / 2 - 1);

    logic        wr;
    logic        rd;
    logic        rd_buf;
    logic        en;
    logic [15:0] div;
    logic [7:0]  rd_data;
    logic [7:0]  rx_buf;

    assign wr     = iocs & ~iorw;
    assign rd     = iocs & iorw;
    assign rd_buf = rd && (ioaddr == ADDR_BUF);

    spart_baud_gen #(
        .RESET_DIV(DEFAULT_DIV)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .we   (wr),
        .addr (ioaddr),
        .wdata(databus),
        .div  (div),
        .en   (en)
    );

    always_comb begin
        rd_data = rx_buf;
        case (ioaddr)
            ADDR_BUF:  rd_data = rx_buf;
            ADDR_STAT: rd_data = {6'b0, tbr, rda};
            ADDR_DBL:  rd_data = div[7:0];
            ADDR_DBH:  rd_data = div[15:8];
        endcase
    end

    assign databus = rd ? rd_data : 8'bz;

    tx_state_t  tx_state;
    logic [3:0] tx_tick;
    logic [2:0] tx_idx;
    logic [7:0] tx_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_tick  <= 4'd0;
            tx_idx   <= 3'd0;
            tx_sh    <= 8'h00;
            txd      <= 1'b1;
            tbr      <= 1'b1;
        end else begin
            if (wr && ioaddr == ADDR_BUF && tbr) begin
                tx_sh <= databus;
                tbr   <= 1'b0;
            end
            if (en) begin
                // The 4-bit tick wraps to 0 exactly at each bit boundary.
                tx_tick <= (tx_state == TX_IDLE) ? 4'd0 : tx_tick + 4'd1;
                case (tx_state)
                    TX_IDLE: begin
                        if (!tbr) begin
                            tx_state <= TX_START;
                            txd      <= 1'b0;
                        end
                    end
                    TX_START: begin
                        if (tx_tick == LAST_TICK) begin
                            tx_state <= TX_DATA;
                            tx_idx   <= 3'd0;
                            txd      <= tx_sh[0];
                            tx_sh    <= tx_sh >> 1;
                        end
                    end
                    TX_DATA: begin
                        if (tx_tick == LAST_TICK) begin
                            if (tx_idx == 3'd7) begin
                                tx_state <= TX_STOP;
                                txd      <= 1'b1;
                            end else begin
                                tx_idx <= tx_idx + 3'd1;
                                txd    <= tx_sh[0];
                                tx_sh  <= tx_sh >> 1;
                            end
                        end
                    end
                    TX_STOP: begin
                        if (tx_tick == LAST_TICK) begin
                            tx_state <= TX_IDLE;
                            tbr      <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    rx_state_t  rx_state;
    logic [3:0] rx_tick;
    logic [2:0] rx_idx;
    logic [7:0] rx_sh;
    logic       rx_meta;
    logic       rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_state <= RX_IDLE;
            rx_tick  <= 4'd0;
            rx_idx   <= 3'd0;
            rx_sh    <= 8'h00;
            rx_buf   <= 8'h00;
            rda      <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
            if (rd_buf)
                rda <= 1'b0;
            if (en) begin
                case (rx_state)
                    RX_IDLE: begin
                        rx_tick <= 4'd0;
                        if (!rx_s)
                            rx_state <= RX_START;
                    end
                    RX_START: begin
                        if (rx_tick == MID_TICK) begin
                            rx_tick  <= 4'd0;
                            rx_idx   <= 3'd0;
                            rx_state <= rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tick <= rx_tick + 4'd1;
                        end
                    end
                    RX_DATA: begin
                        rx_tick <= rx_tick + 4'd1;
                        if (rx_tick == LAST_TICK) begin
                            rx_sh  <= {rx_s, rx_sh[7:1]};
                            rx_idx <= rx_idx + 3'd1;
                            if (rx_idx == 3'd7)
                                rx_state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        rx_tick <= rx_tick + 4'd1;
                        if (rx_tick == LAST_TICK) begin
                            rx_state <= RX_IDLE;
                            // A completing byte wins over a same-cycle read clear.
                            if (rx_s) begin
                                rx_buf <= rx_sh;
                                rda    <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spart_core.sv
// Randomized self-checking bench for spart_core against a frame-level model.
`timescale 1ns/1ps
module tb_spart_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    wire  [7:0] databus;
    logic [7:0] drv = 8'h00;
    logic       drv_en = 1'b0;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd;
    logic       rxd_drv = 1'b1;
    logic       loop = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    int         div_m = 1302;
    logic [7:0] exp_buf = 8'h00;
    logic       exp_rda = 1'b0;
    logic [7:0] rv;

    assign databus = drv_en ? drv : 8'bz;
    assign rxd = loop ? txd : rxd_drv;

    always #5 clk = ~clk;

    spart_core dut (
        .clk    (clk),
        .rst    (rst),
        .iocs   (iocs),
        .iorw   (iorw),
        .ioaddr (ioaddr),
        .databus(databus),
        .rda    (rda),
        .tbr    (tbr),
        .txd    (txd),
        .rxd    (rxd)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv = d; drv_en = 1'b1;
        @(negedge clk);
        iocs = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic set_div(input int d);
        bus_write(2'b10, 8'(d));
        bus_write(2'b11, 8'(d >> 8));
        div_m = d;
    endtask

    task automatic wait_tbr(input int lim);
        int k = 0;
        while (!tbr && k < lim) begin
            @(negedge clk);
            k++;
        end
        check("tbr_wait", tbr, 1);
    endtask

    task automatic read_buf(input string tag);
        bus_read(2'b00, rv);
        check(tag, rv, exp_buf);
        exp_rda = 1'b0;
        check({tag, "_rda_clr"}, rda, 0);
    endtask

    task automatic tx_frame(input logic [7:0] b);
        int bt = 16 * (div_m + 1);
        int k = 0;
        logic [9:0] frame = {1'b1, b, 1'b0};
        wait_tbr(bt * 12);
        bus_write(2'b00, b);
        check("tx_tbr_low", tbr, 0);
        bus_write(2'b00, ~b);
        while (txd && k < 4 * (div_m + 1) + 8) begin
            @(negedge clk);
            k++;
        end
        check("tx_start_seen", txd, 0);
        repeat (bt / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), txd, frame[i]);
            if (i == 9)
                check("tx_tbr_in_stop", tbr, 0);
            repeat (bt) @(negedge clk);
        end
        check("tx_tbr_back", tbr, 1);
        check("tx_idle", txd, 1);
    endtask

    task automatic rx_send(input logic [7:0] b, input bit stop_ok);
        int bt = 16 * (div_m + 1);
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (bt) @(negedge clk);
        end
        if (stop_ok) begin
            rxd_drv = 1'b1;
            repeat (bt) @(negedge clk);
        end else begin
            rxd_drv = 1'b0;
            repeat (bt / 2 + 3 * (div_m + 1) + 4) @(negedge clk);
            rxd_drv = 1'b1;
            repeat (bt) @(negedge clk);
        end
        repeat (bt) @(negedge clk);
        if (stop_ok) begin
            exp_buf = b;
            exp_rda = 1'b1;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bt;
        logic [7:0] b;
        bit ok;

        #2 rst = 1'b1;
        #1;
        check("rst_txd", txd, 1);
        check("rst_tbr", tbr, 1);
        check("rst_rda", rda, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus_read(2'b01, rv);
        check("rst_status", rv, 8'h02);
        bus_read(2'b10, rv);
        check("rst_dbl", rv, 8'h16);
        bus_read(2'b11, rv);
        check("rst_dbh", rv, 8'h05);
        bus_read(2'b00, rv);
        check("rst_rxbuf", rv, 8'h00);

        set_div(4);
        bus_read(2'b10, rv);
        check("div_lo", rv, 8'h04);
        bus_read(2'b11, rv);
        check("div_hi", rv, 8'h00);

        k = 0;
        while (!dut.u_baud.en && k < 20) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!dut.u_baud.en && k < 100);
        check("en_period", 16'(k), 16'(div_m + 1));

        tx_frame(8'hA5);
        for (int n = 0; n < 3; n++) begin
            set_div($urandom_range(0, 3));
            tx_frame(8'($urandom));
        end

        set_div(4);
        bt = 16 * (div_m + 1);
        loop = 1'b1;
        repeat (bt) @(negedge clk);
        bus_write(2'b00, 8'h3C);
        k = 0;
        while (!rda && k < 12 * bt) begin
            @(negedge clk);
            k++;
        end
        check("lb_rda", rda, 1);
        check("lb_latency", (k >= 9 * bt && k <= 11 * bt), 1);
        exp_buf = 8'h3C;
        read_buf("lb_data");
        wait_tbr(bt * 4);
        repeat (bt) @(negedge clk);
        loop = 1'b0;

        rxd_drv = 1'b0;
        repeat (3 * (div_m + 1)) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (2 * bt) @(negedge clk);
        check("false_start_rda", rda, 0);

        rx_send(8'h5A, 1'b0);
        check("frame_err_rda", rda, 0);
        bus_read(2'b00, rv);
        check("frame_err_buf", rv, exp_buf);

        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        check("overrun_rda", rda, 1);
        read_buf("overrun_data");

        for (int n = 0; n < 8; n++) begin
            set_div($urandom_range(1, 4));
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            rx_send(b, ok);
            check($sformatf("rx_rda_%0d", n), rda, exp_rda);
            if ($urandom_range(0, 1) == 1)
                read_buf($sformatf("rx_data_%0d", n));
        end

        rx_send(8'h77, 1'b1);
        check("pre_rst_rda", rda, 1);
        bus_write(2'b00, 8'hFF);
        k = 0;
        while (txd && k < 4 * (div_m + 1) + 8) begin
            @(negedge clk);
            k++;
        end
        check("mid_start_seen", txd, 0);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_tbr", tbr, 1);
        check("mid_rst_rda", rda, 0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(2'b01, rv);
        check("mid_rst_status", rv, 8'h02);
        bus_read(2'b10, rv);
        check("mid_rst_dbl", rv, 8'h16);
        bus_read(2'b00, rv);
        check("mid_rst_rxbuf", rv, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
